// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter with frame and last-bit strobes.
//
// Accepts a DW-bit word over a valid/ready handshake and shifts it out one bit
// per clock on o_data, with o_frame high on every frame bit and o_last on the
// final bit. Optional even parity bit appended when PISO_TX_PARITY_EN is defined.
//
// Parameters:
//   DW        data word width in bits (2..32)
//   MSB_FIRST 1: bit DW-1 is sent first, 0: bit 0 is sent first
//
// Ports:
//   clk      system clock, rising edge
//   i_rst    synchronous active-high reset
//   i_valid  word available on i_data
//   i_data   parallel word, sampled only on the accept edge
//   o_ready  transmitter can accept a word this cycle (combinational)
//   o_data   serial bit (registered)
//   o_frame  high while o_data carries a frame bit (registered)
//   o_last   high on the final bit of a frame (registered)
//
// Build option: PISO_TX_PARITY_EN adds the PAR state and a trailing even
// parity bit; the frame becomes DW+1 bits with o_last on the parity bit.

module piso_tx #(
    parameter int DW        = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    output logic          o_data,
    output logic          o_frame,
    output logic          o_last
);

    localparam int            CW   = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] sh_q, sh_d;
    logic          data_q, data_d;
    logic          frame_q, frame_d;
    logic          last_q, last_d;
    logic          ready;
    logic          load;
`ifdef PISO_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    // Bit currently at the head of the shift register, in transmit order.
    function automatic logic head(input logic [DW-1:0] w);
        if (MSB_FIRST) begin
            head = w[DW-1];
        end else begin
            head = w[0];
        end
    endfunction

    // Shift register advanced by one bit toward the head.
    function automatic logic [DW-1:0] adv(input logic [DW-1:0] w);
        if (MSB_FIRST) begin
            adv = {w[DW-2:0], 1'b0};
        end else begin
            adv = {1'b0, w[DW-1:1]};
        end
    endfunction

    // Next-state, handshake and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        ready   = 1'b0;
        load    = 1'b0;
        data_d  = 1'b0;
        frame_d = 1'b0;
        last_d  = 1'b0;
`ifdef PISO_TX_PARITY_EN
        par_d   = par_q;
`endif

        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
            end
            SHIFT: begin
`ifdef PISO_TX_PARITY_EN
                // Running parity includes the bit on the line this cycle.
                par_d = par_q ^ head(sh_q);
`endif
                if (cnt_q == LAST) begin
`ifdef PISO_TX_PARITY_EN
                    state_d = PAR;
`else
                    ready   = 1'b1;
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    sh_d  = adv(sh_q);
                end
            end
`ifdef PISO_TX_PARITY_EN
            PAR: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // A word accepted on the final frame cycle starts the next frame
        // immediately, so back-to-back frames have no gap.
        load = i_valid && ready;
        if (load) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sh_d    = i_data;
`ifdef PISO_TX_PARITY_EN
            par_d   = 1'b0;
`endif
        end

        // Outputs are registered: compute what the line shows next cycle.
        if (state_d == SHIFT) begin
            data_d  = head(sh_d);
            frame_d = 1'b1;
`ifndef PISO_TX_PARITY_EN
            last_d  = (cnt_d == LAST);
`endif
        end
`ifdef PISO_TX_PARITY_EN
        if (state_d == PAR) begin
            data_d  = par_d;
            frame_d = 1'b1;
            last_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= 1'b0;
            frame_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            frame_q <= frame_d;
            last_q  <= last_d;
`ifdef PISO_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign o_ready = ready;
    assign o_data  = data_q;
    assign o_frame = frame_q;
    assign o_last  = last_q;

endmodule
